// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and sizing helper for digit_serial_adder
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Digit counter width: clog2 of the digit count, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_add.sv
// rtl/digit_add.sv - combinational DIGIT-bit adder with carry in/out
module digit_add #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    // Zero-extend every term so the carry lands in the extra top bit
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle adder, DIGIT bits per clock, wrap/saturate
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sat_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    logic [1:0]       state;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             sat_r;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;

    // Operands shift right one digit per cycle, so the current digit is always the low slice
    digit_add #(.DIGIT(DIGIT)) u_digit_add (
        .x  (a_r[DIGIT-1:0]),
        .y  (b_r[DIGIT-1:0]),
        .ci (carry),
        .s  (dsum),
        .co (dcarry)
    );

    // Result fills from the top: after N digits, digit k sits in slice k
    always_comb begin
        res_next = res >> DIGIT;
        res_next[WIDTH-1 -: DIGIT] = dsum;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res   <= '0;
            carry <= 1'b0;
            sat_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        sat_r <= sat_mode;
                        res   <= '0;
                        k     <= '0;
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_r   <= a_r >> DIGIT;
                    b_r   <= b_r >> DIGIT;
                    res   <= res_next;
                    carry <= dcarry;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are masked to zero whenever no result is presented
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        sum       = '0;
        cout      = 1'b0;
        if (out_valid) begin
            sum  = (sat_r && carry) ? {WIDTH{1'b1}} : res;
            cout = carry;
        end
        ovf = cout;
    end

endmodule
